// File: rtl/stepper_move_sequencer_pkg.sv
// Shared types and constants for the stepper move sequencer.
// Holds the FSM state enum, coil pattern table and default minimum period.
package stepper_pkg;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  localparam int MIN_PERIOD_DEF = 1000;

  // Active-low one-hot coil select, indexed by phase.
  localparam logic [3:0] COIL_N_TAB [4] = '{
    4'b1110,
    4'b1101,
    4'b1011,
    4'b0111
  };

  function automatic logic [3:0] coil_n_of(
    input logic [1:0] ph
  );
    return COIL_N_TAB[ph];
  endfunction

endpackage

// File: rtl/stepper_move_sequencer_if.sv
// Move command valid/ready bundle.
// master: command source (CPU side); slave: the sequencer.
interface stepper_move_sequencer_if #(
  parameter int CNT_W = 16,
  parameter int PER_W = 20
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_steps;
  logic [PER_W-1:0] cmd_period;

  modport master (
    output cmd_valid,
    output cmd_dir,
    output cmd_steps,
    output cmd_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_dir,
    input  cmd_steps,
    input  cmd_period,
    output cmd_ready
  );
endinterface

// File: rtl/stepper_rate_timer.sv
// Reloadable down-counter; o_tick is high while enabled and at zero.
// Ports: i_load/i_val preset, i_en counts down and reloads i_val on tick.
module stepper_rate_timer #(
  parameter int PER_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [PER_W-1:0] i_val,
  output logic             o_tick
);

  logic [PER_W-1:0] r_cnt;
  logic             w_zero;

  assign w_zero = (r_cnt == '0);
  assign o_tick = i_en && w_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_en) begin
      r_cnt <= w_zero ? i_val : r_cnt - PER_W'(1);
    end
  end

endmodule

// File: rtl/stepper_move_sequencer.sv
// Counted, rate-limited, abortable move engine for a 4-phase stepper.
// Ports: cmd bundle (if), abort, hold_en; status busy/done/aborted/
// steps_left/position; coil pins drive_en and active-low coil_n.
module stepper_move_sequencer
  import stepper_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int PER_W      = 20,
  parameter int MIN_PERIOD = MIN_PERIOD_DEF,
  parameter int POS_W      = 32
) (
  input  logic                    clock_clk,
  input  logic                    reset_reset,
  stepper_move_sequencer_if.slave cmd,
  input  logic                    abort,
  input  logic                    hold_en,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic [CNT_W-1:0]        steps_left,
  output logic signed [POS_W-1:0] position,
  output logic [1:0]              drive_en,
  output logic [3:0]              coil_n
);

  state_t                  r_state;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_aborted;
  logic                    r_dir;
  logic [1:0]              r_phase;
  logic [CNT_W-1:0]        r_steps_left;
  logic signed [POS_W-1:0] r_position;
  logic [PER_W-1:0]        r_reload;
  logic [1:0]              r_drive_en;
  logic [3:0]              r_coil_n;

  logic             w_accept;
  logic             w_run;
  logic             w_tick;
  logic             w_step;
  logic             w_last;
  logic [PER_W-1:0] w_eff;
  logic [PER_W-1:0] w_load_val;
  logic [1:0]       w_phase_step;
  logic [1:0]       w_phase_n;
  logic             w_busy_n;

  assign cmd.cmd_ready = (r_state == S_IDLE)
                      && !abort && !reset_reset;

  assign w_accept = cmd.cmd_valid && cmd.cmd_ready;
  assign w_run    = (r_state == S_RUN) && !abort;
  assign w_step   = w_run && w_tick;
  assign w_last   = (r_steps_left == CNT_W'(1));

  assign w_eff = (cmd.cmd_period < PER_W'(MIN_PERIOD))
               ? PER_W'(MIN_PERIOD) : cmd.cmd_period;

  assign w_load_val = w_accept ? w_eff - PER_W'(1) : r_reload;

  assign w_phase_step = r_dir ? r_phase + 2'd1
                              : r_phase - 2'd1;

  stepper_rate_timer #(
    .PER_W (PER_W)
  ) u_timer (
    .clk    (clock_clk),
    .rst    (reset_reset),
    .i_load (w_accept),
    .i_en   (w_run),
    .i_val  (w_load_val),
    .o_tick (w_tick)
  );

  // Next phase/busy feed the registered coil outputs so the pins
  // change on the same edge as the step or state change.
  always_comb begin
    w_phase_n = w_step ? w_phase_step : r_phase;
    w_busy_n  = 1'b0;
    unique case (r_state)
      S_IDLE:  w_busy_n = w_accept && (cmd.cmd_steps != '0);
      S_RUN:   w_busy_n = !abort && !(w_tick && w_last);
      default: w_busy_n = 1'b0;
    endcase
  end

  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_dir        <= 1'b0;
      r_phase      <= 2'd0;
      r_steps_left <= '0;
      r_position   <= '0;
      r_reload     <= '0;
      r_drive_en   <= 2'b00;
      r_coil_n     <= 4'b1111;
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (cmd.cmd_steps == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state      <= S_RUN;
              r_busy       <= 1'b1;
              r_dir        <= cmd.cmd_dir;
              r_steps_left <= cmd.cmd_steps;
              r_reload     <= w_eff - PER_W'(1);
            end
          end
        end
        S_RUN: begin
          // Abort takes priority over a step due on the same edge.
          if (abort) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_aborted <= 1'b1;
          end else if (w_tick) begin
            r_phase      <= w_phase_step;
            r_steps_left <= r_steps_left - CNT_W'(1);
            r_position   <= r_dir ? r_position + POS_W'(1)
                                  : r_position - POS_W'(1);
            if (w_last) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_busy_n || hold_en) begin
        r_drive_en <= 2'b11;
        r_coil_n   <= coil_n_of(w_phase_n);
      end else begin
        r_drive_en <= 2'b00;
        r_coil_n   <= 4'b1111;
      end
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign aborted    = r_aborted;
  assign steps_left = r_steps_left;
  assign position   = r_position;
  assign drive_en   = r_drive_en;
  assign coil_n     = r_coil_n;

endmodule

// File: tb/tb_stepper_move_sequencer.sv
// Directed bench for stepper_move_sequencer.
// Checks moves, clamping, zero-step, abort, hold and reset.
module tb_stepper_move_sequencer;

  logic        clk;
  logic        rst;
  logic        abort;
  logic        hold_en;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] steps_left;
  logic signed [31:0] position;
  logic [1:0]  drive_en;
  logic [3:0]  coil_n;

  int npass;
  int ntot;

  stepper_move_sequencer_if #(
    .CNT_W (16),
    .PER_W (20)
  ) cmd_if ();

  stepper_move_sequencer #(
    .CNT_W      (16),
    .PER_W      (20),
    .MIN_PERIOD (1000),
    .POS_W      (32)
  ) dut (
    .clock_clk   (clk),
    .reset_reset (rst),
    .cmd         (cmd_if.slave),
    .abort       (abort),
    .hold_en     (hold_en),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .steps_left  (steps_left),
    .position    (position),
    .drive_en    (drive_en),
    .coil_n      (coil_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic wn(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(
    input logic        dir,
    input logic [15:0] steps,
    input logic [19:0] per
  );
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_dir    = dir;
    cmd_if.cmd_steps  = steps;
    cmd_if.cmd_period = per;
    @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
  endtask

  initial begin
    npass = 0;
    ntot  = 0;
    rst   = 1'b1;
    abort = 1'b0;
    hold_en = 1'b0;
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_dir    = 1'b0;
    cmd_if.cmd_steps  = '0;
    cmd_if.cmd_period = '0;
    wn(3);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_abt", 64'(aborted), 64'd0);
    chk("rst_left", 64'(steps_left), 64'd0);
    chk("rst_pos", 64'(position), 64'd0);
    chk("rst_drv", 64'(drive_en), 64'd0);
    chk("rst_coil", 64'(coil_n), 64'hf);
    chk("rst_rdy", 64'(cmd_if.cmd_ready), 64'd0);
    rst = 1'b0;
    hold_en = 1'b1;
    wn(2);
    chk("idle_rdy", 64'(cmd_if.cmd_ready), 64'd1);

    // forward 5 steps, period 2000
    issue(1'b1, 16'd5, 20'd2000);
    chk("m1_busy", 64'(busy), 64'd1);
    chk("m1_coil0", 64'(coil_n), 64'he);
    chk("m1_drv", 64'(drive_en), 64'd3);
    chk("m1_left0", 64'(steps_left), 64'd5);
    chk("m1_rdy", 64'(cmd_if.cmd_ready), 64'd0);
    wn(1999);
    chk("m1_pre1", 64'(coil_n), 64'he);
    wn(1);
    chk("m1_coil1", 64'(coil_n), 64'hd);
    chk("m1_pos1", 64'(position), 64'd1);
    chk("m1_left1", 64'(steps_left), 64'd4);
    wn(2000);
    chk("m1_coil2", 64'(coil_n), 64'hb);
    wn(2000);
    chk("m1_coil3", 64'(coil_n), 64'h7);
    wn(2000);
    chk("m1_coil4", 64'(coil_n), 64'he);
    wn(1999);
    chk("m1_prebusy", 64'(busy), 64'd1);
    chk("m1_predone", 64'(done), 64'd0);
    wn(1);
    chk("m1_done", 64'(done), 64'd1);
    chk("m1_busy0", 64'(busy), 64'd0);
    chk("m1_pos", 64'(position), 64'd5);
    chk("m1_left", 64'(steps_left), 64'd0);
    chk("m1_coil5", 64'(coil_n), 64'hd);
    wn(1);
    chk("m1_done1c", 64'(done), 64'd0);

    // hold off while idle
    hold_en = 1'b0;
    wn(1);
    chk("idle_drv", 64'(drive_en), 64'd0);
    chk("idle_coil", 64'(coil_n), 64'hf);

    // reverse 2 steps, period 10 clamped to 1000
    issue(1'b0, 16'd2, 20'd10);
    hold_en = 1'b1;
    chk("m2_coil0", 64'(coil_n), 64'hd);
    wn(999);
    chk("m2_clamp", 64'(coil_n), 64'hd);
    wn(1);
    chk("m2_coil1", 64'(coil_n), 64'he);
    chk("m2_pos1", 64'(position), 64'd4);
    wn(1000);
    chk("m2_coil2", 64'(coil_n), 64'h7);
    chk("m2_pos", 64'(position), 64'd3);
    chk("m2_done", 64'(done), 64'd1);

    // zero-step command
    wn(1);
    issue(1'b1, 16'd0, 20'd1000);
    chk("z_done", 64'(done), 64'd1);
    chk("z_busy", 64'(busy), 64'd0);
    chk("z_coil", 64'(coil_n), 64'h7);
    chk("z_pos", 64'(position), 64'd3);
    wn(1);
    chk("z_done1c", 64'(done), 64'd0);
    chk("z_busy1", 64'(busy), 64'd0);

    // abort in idle only blocks ready
    abort = 1'b1;
    #1;
    chk("ia_rdy", 64'(cmd_if.cmd_ready), 64'd0);
    wn(1);
    chk("ia_abt", 64'(aborted), 64'd0);
    abort = 1'b0;
    wn(1);

    // abort at accept+2500 of a 10-step move
    issue(1'b1, 16'd10, 20'd1000);
    wn(2499);
    chk("a1_pre", 64'(busy), 64'd1);
    abort = 1'b1;
    wn(1);
    abort = 1'b0;
    chk("a1_abt", 64'(aborted), 64'd1);
    chk("a1_busy", 64'(busy), 64'd0);
    chk("a1_done", 64'(done), 64'd0);
    chk("a1_left", 64'(steps_left), 64'd8);
    chk("a1_pos", 64'(position), 64'd5);
    chk("a1_coil", 64'(coil_n), 64'hd);
    wn(1);
    chk("a1_abt1c", 64'(aborted), 64'd0);

    // abort on the timer-zero edge: no step
    issue(1'b1, 16'd10, 20'd1000);
    wn(1000);
    chk("a2_pos1", 64'(position), 64'd6);
    wn(999);
    abort = 1'b1;
    wn(1);
    abort = 1'b0;
    chk("a2_abt", 64'(aborted), 64'd1);
    chk("a2_left", 64'(steps_left), 64'd9);
    chk("a2_pos", 64'(position), 64'd6);
    chk("a2_coil", 64'(coil_n), 64'hb);

    // phase retained through an unheld idle
    hold_en = 1'b0;
    wn(1);
    chk("h0_coil", 64'(coil_n), 64'hf);
    issue(1'b1, 16'd1, 20'd1000);
    chk("r_coil0", 64'(coil_n), 64'hb);
    wn(1000);
    chk("r_done", 64'(done), 64'd1);
    chk("r_pos", 64'(position), 64'd7);
    chk("r_coil", 64'(coil_n), 64'hf);
    hold_en = 1'b1;
    wn(1);
    chk("r_hold", 64'(coil_n), 64'h7);

    // back-to-back with cmd_valid held across done
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_dir    = 1'b0;
    cmd_if.cmd_steps  = 16'd1;
    cmd_if.cmd_period = 20'd1000;
    @(posedge clk);
    @(negedge clk);
    chk("b_busy", 64'(busy), 64'd1);
    chk("b_rdy0", 64'(cmd_if.cmd_ready), 64'd0);
    wn(1000);
    chk("b_done", 64'(done), 64'd1);
    chk("b_busy0", 64'(busy), 64'd0);
    chk("b_rdy1", 64'(cmd_if.cmd_ready), 64'd1);
    chk("b_pos1", 64'(position), 64'd6);
    wn(1);
    cmd_if.cmd_valid = 1'b0;
    chk("b2_busy", 64'(busy), 64'd1);
    chk("b2_done", 64'(done), 64'd0);
    chk("b2_left", 64'(steps_left), 64'd1);
    wn(1000);
    chk("b2_fin", 64'(done), 64'd1);
    chk("b2_pos", 64'(position), 64'd5);

    // reset mid-move
    wn(2);
    issue(1'b1, 16'd5, 20'd1000);
    wn(1500);
    chk("mr_pos", 64'(position), 64'd6);
    rst = 1'b1;
    wn(1);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_done", 64'(done), 64'd0);
    chk("mr_abt", 64'(aborted), 64'd0);
    chk("mr_left", 64'(steps_left), 64'd0);
    chk("mr_pos0", 64'(position), 64'd0);
    chk("mr_drv", 64'(drive_en), 64'd0);
    chk("mr_coil", 64'(coil_n), 64'hf);
    chk("mr_rdy", 64'(cmd_if.cmd_ready), 64'd0);
    rst = 1'b0;
    wn(2);
    chk("mr_done2", 64'(done), 64'd0);
    chk("mr_coilh", 64'(coil_n), 64'he);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/stepper_move_sequencer.md
# stepper_move_sequencer

Command-driven sequencer for one 4-phase unipolar stepper coil driver: accepts move commands (direction, step count, step period) over a valid/ready handshake and walks the coil phase pattern at the commanded rate. It tracks absolute position and reports completion or abort. It replaces free-running phase stepping with a counted, rate-limited, abortable move engine, and sits between the forklift motion CPU interface and the coil driver pins.

## Interface
- CNT_W, 16, width of step count and steps_left
- PER_W, 20, width of step period in clocks
- MIN_PERIOD, 1000, minimum clocks between steps; smaller commanded periods are clamped up
- POS_W, 32, width of signed absolute position
- clock_clk  in  1  system clock, all logic on rising edge
- reset_reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_dir  in  1  1 = forward (phase +1, position +1), 0 = reverse
- cmd_steps  in  CNT_W  number of steps, unsigned
- cmd_period  in  PER_W  clocks between steps, unsigned
- abort  in  1  stop current move at next edge
- hold_en  in  1  keep current coil energized while idle
- busy  out  1  move in progress
- done  out  1  one-cycle pulse, move completed normally
- aborted  out  1  one-cycle pulse, move terminated by abort
- steps_left  out  CNT_W  remaining steps of current move
- position  out  POS_W  signed absolute step count, two's complement wrap
- drive_en  out  2  bridge enables
- coil_n  out  4  active-low one-hot coil select

## Operation
- States: IDLE, RUN. Reset → IDLE.
- Reset values: busy 0, done 0, aborted 0, steps_left 0, position 0, phase 0, drive_en 2'b00, coil_n 4'b1111. cmd_ready 0 while reset_reset is high.
- cmd_ready = (state == IDLE) && !abort && !reset_reset; the only combinational output.
- Accept in IDLE: latch dir, steps_left = cmd_steps, eff_period = max(cmd_period, MIN_PERIOD); load timer with eff_period−1; go RUN, busy 1.
- cmd_steps = 0: accepted, no move; next edge stays IDLE, done = 1 for one cycle, busy stays 0, phase/position unchanged.
- RUN: timer decrements each cycle. At timer == 0: step. Phase ±1 mod 4 (3→0 forward, 0→3 reverse), position ±1, steps_left −1, timer reloads eff_period−1.
- Step that takes steps_left to 0: same edge → IDLE, busy 0, done 1 for one cycle.
- abort high in RUN: next edge → IDLE, busy 0, aborted 1 for one cycle, steps_left holds remaining count, no step on that edge even if timer == 0 (abort wins). abort in IDLE: no effect except blocking cmd_ready.
- Coil outputs: when busy || hold_en: drive_en = 2'b11, coil_n = ~(4'b0001 << phase). Otherwise drive_en = 2'b00, coil_n = 4'b1111. Phase is retained across idle periods.
- cmd_* inputs are ignored while busy; no queueing.
- reset_reset mid-move: next edge returns to all reset values, no done/aborted pulse.

## Timing
- All outputs except cmd_ready are registered.
- Accept at edge N: busy, drive_en and coil_n valid after N. First step at edge N + eff_period; step k at N + k·eff_period.
- done/aborted are high for exactly one cycle, coincident with busy falling. cmd_ready may be high in that same cycle, so back-to-back moves have a one-step-period minimum spacing and no dead cycle.
- Position, phase and steps_left update on the same edge.

## Structure
- Package stepper_pkg: state enum, phase-to-coil_n constant table, default MIN_PERIOD.
- One sub-module: stepper_rate_timer, a reloadable down-counter. Inputs are load, reload value and enable; output is a tick on zero.

## Test plan
- Reset then forward move (steps 5, period 2000): coil_n 1110→1101→1011→0111→1110 at accept+2000·k; position 5; done at step 5; busy 5 cycles-exact window of 10000 clocks.
- Reverse move from phase 0 (steps 2, period 10, MIN_PERIOD 1000): clamped to 1000; coil_n 0111 then 1011; position −2.
- cmd_steps 0: done pulse one cycle after accept, busy never high, coil_n unchanged.
- Abort at accept+2500 during a 10-step move at period 1000: aborted pulse, steps_left 8, position 2. Abort coincident with timer zero: no third step.
- Idle behaviour: hold_en 0 → drive_en 00, coil_n 1111. hold_en 1 → last coil stays energized. Next move resumes from the retained phase.
- reset_reset asserted mid-move: all outputs return to reset values next edge with no done pulse. cmd_valid held across done: second move accepted in the done cycle.
